fir_coeff_loader: RTL and testbench
===================================

// Module: fir_coeff_loader
// PURPOSE
//  Host-side coefficient supplier for the 33-tap direct-form FIR datapath. A host writes/reads
//  taps over a simple CSn/WrEn register bus into a shadow bank; on request the shadow bank
//  is copied atomically into the active bank that drives the FIR coefficient inputs.
//  The swap never occurs on a cycle where the FIR is accumulating (iEnAcc=1), so no output sample mixes old/new taps.
// PARAMETERS
//  NUM_TAPS  33  number of coefficients (addresses 0..NUM_TAPS-1; addr k drives oCoeff(k+1))
//  DATA_W    16  signed coefficient width
//  ADDR_W    6   host address width
// PORTS
//  iClk_12M     in   1       system clock, all logic on rising edge
//  iRsn         in   1       asynchronous active-low reset
//  iCsn         in   1       host chip select, active low; one access per cycle while low
//  iWrEn        in   1       1=write, 0=read (qualified by iCsn=0)
//  iAddr        in   ADDR_W  tap address
//  iWrDt        in   DATA_W  write data (signed)
//  iRdSel       in   1       read source: 0=shadow bank, 1=active bank (sampled with read)
//  iUpdateReq   in   1       one-cycle pulse: request shadow->active copy
//  iEnAcc       in   1       FIR accumulate enable (same strobe the FIR consumes)
//  oRdDt        out  DATA_W  read data, valid when oRdValid=1, else held
//  oRdValid     out  1       one-cycle pulse, read data valid
//  oAddrErr     out  1       one-cycle pulse, access to address >= NUM_TAPS
//  oUpdBusy     out  1       1 while a copy request is pending
//  oUpdDone     out  1       one-cycle pulse on the cycle after the copy is applied
//  oCoeff1..oCoeff33 out DATA_W each  active-bank coefficients to FIR (registered outputs)
// BEHAVIOUR
//  Reset (iRsn=0, async): shadow and active banks = 0, all oCoeff* = 0, oRdDt=0, oRdValid=0,
//   oAddrErr=0, oUpdBusy=0, oUpdDone=0, FSM=IDLE. Reset mid-pending discards the request.
//  Write: iCsn=0,iWrEn=1,iAddr<NUM_TAPS -> shadow[iAddr]<=iWrDt at that edge. Active bank untouched.
//  Read: iCsn=0,iWrEn=0 -> next cycle oRdValid=1, oRdDt=(iRdSel?active:shadow)[iAddr]
//   sampled at the request edge (1-cycle latency). Back-to-back reads allowed every cycle.
//  Bad address (iAddr>=NUM_TAPS): write ignored; read returns oRdDt=0 with oRdValid=1;
//   oAddrErr=1 next cycle for either access type.
//  FSM states: IDLE, PEND.
//   IDLE: iUpdateReq=1 & iEnAcc=0 -> copy this edge (active<=shadow), oUpdDone=1 next cycle, stay IDLE.
//         iUpdateReq=1 & iEnAcc=1 -> PEND, oUpdBusy=1 from next cycle.
//   PEND: first edge with iEnAcc=0 -> copy, ->IDLE, oUpdBusy=0 and oUpdDone=1 next cycle.
//         iUpdateReq in PEND ignored (merged into the pending copy); no second oUpdDone.
//  Copy is parallel, single edge, all NUM_TAPS taps; oCoeff* change only on a copy edge.
//  Write+copy same edge: active receives shadow value held BEFORE the write; shadow takes new
//   data (next copy carries it). Read of active on copy edge returns pre-copy value.
//  Host bus has no backpressure; accesses during PEND are legal and target shadow only.
//  No arithmetic: values are stored verbatim, sign bit preserved; no saturation or rounding.
// TESTING
//  Reset: assert iRsn=0 mid-traffic -> all oCoeff*=0, oRdValid=0, oUpdBusy=0 immediately (async).
//  Write shadow[0..32]=k*0x0101 (k=addr), read iRdSel=0 addr 5 -> next cycle oRdDt=0x0505; oCoeff6 still 0.
//  iUpdateReq with iEnAcc=0 -> next edge oCoeff1=0x0000, oCoeff33=0x2020, oUpdDone pulse once.
//  iEnAcc=1 for 4 cycles, iUpdateReq at cycle 0 and 2 -> oUpdBusy high until iEnAcc drops; one copy, one oUpdDone.
//  Write addr 3 = 0x8001 same edge as copy -> oCoeff4 = old shadow[3]=0x0303; next copy -> oCoeff4=0x8001 (negative).
//  Write addr 40 = 0x1234 and read addr 33 -> oAddrErr pulses each, shadow unchanged, read oRdDt=0.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// Shadow/active coefficient banks for the 33-tap FIR. The host bus writes and reads the shadow bank.
// A requested shadow->active copy is held off while the FIR is accumulating.
module fir_coeff_loader #(
    parameter int NUM_TAPS = 33,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6
) (
    input  logic              iClk_12M,
    input  logic              iRsn,
    input  logic              iCsn,
    input  logic              iWrEn,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [DATA_W-1:0] iWrDt,
    input  logic              iRdSel,
    input  logic              iUpdateReq,
    input  logic              iEnAcc,
    output logic [DATA_W-1:0] oRdDt,
    output logic              oRdValid,
    output logic              oAddrErr,
    output logic              oUpdBusy,
    output logic              oUpdDone,
    output logic [DATA_W-1:0] oCoeff1,  oCoeff2,  oCoeff3,  oCoeff4,  oCoeff5,
    output logic [DATA_W-1:0] oCoeff6,  oCoeff7,  oCoeff8,  oCoeff9,  oCoeff10,
    output logic [DATA_W-1:0] oCoeff11, oCoeff12, oCoeff13, oCoeff14, oCoeff15,
    output logic [DATA_W-1:0] oCoeff16, oCoeff17, oCoeff18, oCoeff19, oCoeff20,
    output logic [DATA_W-1:0] oCoeff21, oCoeff22, oCoeff23, oCoeff24, oCoeff25,
    output logic [DATA_W-1:0] oCoeff26, oCoeff27, oCoeff28, oCoeff29, oCoeff30,
    output logic [DATA_W-1:0] oCoeff31, oCoeff32, oCoeff33
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shadow [NUM_TAPS];
    logic [DATA_W-1:0] active [NUM_TAPS];
    logic              addr_ok, wr_hit, rd_hit, copy;
    logic [DATA_W-1:0] rd_src;

    always_comb begin
        addr_ok = (iAddr < ADDR_W'(NUM_TAPS));
        wr_hit  = !iCsn && iWrEn && addr_ok;
        rd_hit  = !iCsn && !iWrEn;
        rd_src  = '0;
        if (addr_ok)
            rd_src = iRdSel ? active[iAddr] : shadow[iAddr];
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) state <= IDLE;
        else       state <= state_nxt;
    end

    // A request seen during accumulation is remembered in PEND; extra requests there merge into it.
    always_comb begin
        state_nxt = state;
        copy      = 1'b0;
        case (state)
            IDLE: begin
                if (iUpdateReq) begin
                    if (iEnAcc) state_nxt = PEND;
                    else        copy      = 1'b1;
                end
            end
            PEND: begin
                if (!iEnAcc) begin
                    copy      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign oUpdBusy = (state == PEND);

    // Nonblocking copy takes the pre-write shadow value when a write lands on the copy edge.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            shadow <= '{default: '0};
            active <= '{default: '0};
        end else begin
            if (wr_hit) shadow[iAddr] <= iWrDt;
            if (copy)   active        <= shadow;
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            oRdDt    <= '0;
            oRdValid <= 1'b0;
            oAddrErr <= 1'b0;
            oUpdDone <= 1'b0;
        end else begin
            oRdValid <= rd_hit;
            oAddrErr <= !iCsn && !addr_ok;
            oUpdDone <= copy;
            if (rd_hit) oRdDt <= rd_src;
        end
    end

    assign oCoeff1  = active[0];
    assign oCoeff2  = active[1];
    assign oCoeff3  = active[2];
    assign oCoeff4  = active[3];
    assign oCoeff5  = active[4];
    assign oCoeff6  = active[5];
    assign oCoeff7  = active[6];
    assign oCoeff8  = active[7];
    assign oCoeff9  = active[8];
    assign oCoeff10 = active[9];
    assign oCoeff11 = active[10];
    assign oCoeff12 = active[11];
    assign oCoeff13 = active[12];
    assign oCoeff14 = active[13];
    assign oCoeff15 = active[14];
    assign oCoeff16 = active[15];
    assign oCoeff17 = active[16];
    assign oCoeff18 = active[17];
    assign oCoeff19 = active[18];
    assign oCoeff20 = active[19];
    assign oCoeff21 = active[20];
    assign oCoeff22 = active[21];
    assign oCoeff23 = active[22];
    assign oCoeff24 = active[23];
    assign oCoeff25 = active[24];
    assign oCoeff26 = active[25];
    assign oCoeff27 = active[26];
    assign oCoeff28 = active[27];
    assign oCoeff29 = active[28];
    assign oCoeff30 = active[29];
    assign oCoeff31 = active[30];
    assign oCoeff32 = active[31];
    assign oCoeff33 = active[32];

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized and directed bench for fir_coeff_loader against a bank-level reference model.
module tb_fir_coeff_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csn, wr_en, rd_sel, upd_req, en_acc;
    logic [5:0]  addr;
    logic [15:0] wr_dt;
    logic [15:0] rd_dt;
    logic        rd_valid, addr_err, upd_busy, upd_done;
    logic [15:0] coeff [33];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [15:0] sh_m [33];
    logic [15:0] ac_m [33];
    bit          pend_m;
    logic [15:0] rd_m;
    bit          valid_m, err_m, done_m;
    int unsigned done_cnt;

    always #5 clk = ~clk;

    fir_coeff_loader #(.NUM_TAPS(33), .DATA_W(16), .ADDR_W(6)) dut (
        .iClk_12M(clk), .iRsn(rst_n), .iCsn(csn), .iWrEn(wr_en), .iAddr(addr),
        .iWrDt(wr_dt), .iRdSel(rd_sel), .iUpdateReq(upd_req), .iEnAcc(en_acc),
        .oRdDt(rd_dt), .oRdValid(rd_valid), .oAddrErr(addr_err),
        .oUpdBusy(upd_busy), .oUpdDone(upd_done),
        .oCoeff1(coeff[0]),   .oCoeff2(coeff[1]),   .oCoeff3(coeff[2]),   .oCoeff4(coeff[3]),
        .oCoeff5(coeff[4]),   .oCoeff6(coeff[5]),   .oCoeff7(coeff[6]),   .oCoeff8(coeff[7]),
        .oCoeff9(coeff[8]),   .oCoeff10(coeff[9]),  .oCoeff11(coeff[10]), .oCoeff12(coeff[11]),
        .oCoeff13(coeff[12]), .oCoeff14(coeff[13]), .oCoeff15(coeff[14]), .oCoeff16(coeff[15]),
        .oCoeff17(coeff[16]), .oCoeff18(coeff[17]), .oCoeff19(coeff[18]), .oCoeff20(coeff[19]),
        .oCoeff21(coeff[20]), .oCoeff22(coeff[21]), .oCoeff23(coeff[22]), .oCoeff24(coeff[23]),
        .oCoeff25(coeff[24]), .oCoeff26(coeff[25]), .oCoeff27(coeff[26]), .oCoeff28(coeff[27]),
        .oCoeff29(coeff[28]), .oCoeff30(coeff[29]), .oCoeff31(coeff[30]), .oCoeff32(coeff[31]),
        .oCoeff33(coeff[32])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 33; i++) begin
            sh_m[i] = '0;
            ac_m[i] = '0;
        end
        pend_m  = 0;
        rd_m    = '0;
        valid_m = 0;
        err_m   = 0;
        done_m  = 0;
    endtask

    task automatic check_all();
        check("rd_valid", {31'd0, rd_valid}, {31'd0, valid_m});
        check("rd_dt",    {16'd0, rd_dt},    {16'd0, rd_m});
        check("addr_err", {31'd0, addr_err}, {31'd0, err_m});
        check("upd_busy", {31'd0, upd_busy}, {31'd0, pend_m});
        check("upd_done", {31'd0, upd_done}, {31'd0, done_m});
        for (int i = 0; i < 33; i++)
            check($sformatf("coeff%0d", i + 1), {16'd0, coeff[i]}, {16'd0, ac_m[i]});
    endtask

    // Applies one bus cycle, advances the model by the same rules, then compares after the edge.
    task automatic cyc(input bit c, input bit w, input int unsigned a, input logic [15:0] d,
                       input bit s, input bit u, input bit e);
        bit ok, want, cp;
        csn = c; wr_en = w; addr = 6'(a); wr_dt = d; rd_sel = s; upd_req = u; en_acc = e;
        ok      = (a < 33);
        valid_m = !c && !w;
        if (valid_m) rd_m = ok ? (s ? ac_m[a] : sh_m[a]) : 16'h0;
        err_m   = !c && !ok;
        want    = pend_m || u;
        cp      = want && !e;
        pend_m  = want && e;
        if (cp) ac_m = sh_m;
        if (!c && w && ok) sh_m[a] = d;
        done_m  = cp;
        @(posedge clk);
        #1;
        if (upd_done) done_cnt++;
        check_all();
    endtask

    task automatic idle(input bit e);
        cyc(1, 0, 0, 16'h0, 0, 0, e);
    endtask

    initial begin
        rst_n = 1'b0;
        csn = 1; wr_en = 0; addr = '0; wr_dt = '0; rd_sel = 0; upd_req = 0; en_acc = 0;
        done_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        for (int k = 0; k < 33; k++)
            cyc(0, 1, k, 16'(k * 16'h0101), 0, 0, 0);
        cyc(0, 0, 5, 16'h0, 0, 0, 0);
        check("read_shadow5", {16'd0, rd_dt}, 32'h0505);
        check("coeff6_before_copy", {16'd0, coeff[5]}, 32'h0);

        done_cnt = 0;
        cyc(1, 0, 0, 16'h0, 0, 1, 0);
        check("coeff1_copy", {16'd0, coeff[0]}, 32'h0);
        check("coeff33_copy", {16'd0, coeff[32]}, 32'h2020);
        idle(0);
        idle(0);
        check("single_done", done_cnt, 1);

        done_cnt = 0;
        cyc(1, 0, 0, 16'h0, 0, 1, 1);
        cyc(0, 1, 7, 16'h7777, 0, 0, 1);
        cyc(1, 0, 0, 16'h0, 0, 1, 1);
        idle(1);
        check("busy_while_acc", {31'd0, upd_busy}, 32'h1);
        check("coeff8_held", {16'd0, coeff[7]}, 32'h0707);
        idle(0);
        check("coeff8_after_pend", {16'd0, coeff[7]}, 32'h7777);
        idle(0);
        idle(0);
        check("merged_done", done_cnt, 1);

        cyc(0, 1, 3, 16'h8001, 0, 1, 0);
        check("coeff4_old", {16'd0, coeff[3]}, 32'h0303);
        cyc(0, 0, 3, 16'h0, 0, 0, 0);
        check("shadow3_new", {16'd0, rd_dt}, 32'h8001);
        cyc(1, 0, 0, 16'h0, 0, 1, 0);
        check("coeff4_neg", {16'd0, coeff[3]}, 32'h8001);

        cyc(0, 1, 40, 16'h1234, 0, 0, 0);
        check("err_wr40", {31'd0, addr_err}, 32'h1);
        cyc(0, 0, 33, 16'h0, 0, 0, 0);
        check("err_rd33", {31'd0, addr_err}, 32'h1);
        check("rd33_zero", {16'd0, rd_dt}, 32'h0);
        idle(0);
        check("err_clears", {31'd0, addr_err}, 32'h0);

        for (int n = 0; n < 1500; n++) begin
            cyc(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
                $urandom_range(0, 40), 16'($urandom), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 2) != 0));
        end

        cyc(1, 0, 0, 16'h0, 0, 1, 1);
        cyc(0, 0, 1, 16'h0, 1, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_rd_valid", {31'd0, rd_valid}, 32'h0);
        check("rst_busy", {31'd0, upd_busy}, 32'h0);
        for (int i = 0; i < 33; i++)
            check($sformatf("rst_coeff%0d", i + 1), {16'd0, coeff[i]}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(0);
        idle(0);
        check("no_done_after_rst", {31'd0, upd_done}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
